// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the IF/D requesters, the arbiter and the RAM.
// slave: arbiter side; master: requester and RAM side.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [STRB_WIDTH-1:0] d_wstrb;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  mem_en;
  logic [STRB_WIDTH-1:0] mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port sync RAM between fetch (IF) and load/store (D).
// Ports: i_clk, i_rst (sync, active high), bus (IF/D/RAM handshake bundle).
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  owner_t     owner_q;
  owner_t     owner_d;
  owner_t     last_q;
  owner_t     last_d;
  logic       wr_q;
  logic       wr_d;

  logic                  if_win;
  logic                  d_win;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] rsp_data;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    unique case (1'b1)
      bus.if_req && !bus.d_req: if_win = 1'b1;
      bus.d_req && !bus.if_req: d_win  = 1'b1;
      bus.if_req && bus.d_req: begin
        if_win = (last_q == OWN_D);
        d_win  = (last_q == OWN_IF);
      end
      default: ;
    endcase
  end

  assign win_addr = if_win ? bus.if_addr : bus.d_addr;

  // Writes are acked with zero data, reads forward the RAM word.
  assign rsp_data = wr_q ? '0 : bus.mem_rdata;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    last_d        = last_q;
    wr_d          = wr_q;
    bus.if_gnt    = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = '0;
    bus.d_gnt     = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.d_rdata   = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    // Everything stays quiet while reset is held, even with a request up.
    if (!i_rst) begin
      unique case (state_q)
        IDLE: begin
          if (if_win || d_win) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = win_addr;
            state_d      = WAIT;
            cnt_d        = CNT_INIT;
          end
          if (if_win) begin
            bus.if_gnt = 1'b1;
            owner_d    = OWN_IF;
            last_d     = OWN_IF;
            wr_d       = 1'b0;
          end
          if (d_win) begin
            bus.d_gnt     = 1'b1;
            bus.mem_wdata = bus.d_wdata;
            bus.mem_we    = bus.d_we ? bus.d_wstrb : '0;
            owner_d       = OWN_D;
            last_d        = OWN_D;
            wr_d          = bus.d_we;
          end
        end
        WAIT: begin
          if (cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
          end else begin
            state_d = IDLE;
            if (owner_q == OWN_IF) begin
              bus.if_rvalid = 1'b1;
              bus.if_rdata  = rsp_data;
            end else begin
              bus.d_rvalid = 1'b1;
              bus.d_rdata  = rsp_data;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      owner_q <= OWN_IF;
      last_q  <= OWN_D;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
    end
  end

endmodule
